// File: rtl/ysyx_25060173_wb_regfile_if.sv
// Writeback / operand-read bus between the execute stage and the register file.
// The master side is the execute stage. The slave side is the writeback
// buffer and register file.
interface ysyx_25060173_wb_regfile_if #(
  parameter int XLEN = 32
) ();
  logic            wb_valid;
  logic            wb_ready;
  logic            wb_wen;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [4:0]      rs1_addr;
  logic [XLEN-1:0] rs1_data;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs2_data;
  logic            commit_valid;
  logic [4:0]      commit_rd;
  logic [XLEN-1:0] commit_data;
  logic            wb_empty;

  modport master (
    output wb_valid, wb_wen, wb_rd, wb_data, rs1_addr, rs2_addr,
    input  wb_ready, rs1_data, rs2_data, commit_valid, commit_rd, commit_data, wb_empty
  );

  modport slave (
    input  wb_valid, wb_wen, wb_rd, wb_data, rs1_addr, rs2_addr,
    output wb_ready, rs1_data, rs2_data, commit_valid, commit_rd, commit_data, wb_empty
  );
endinterface

// File: rtl/ysyx_25060173_wb_regfile.sv
// Writeback buffer plus 32-entry register file.
// ALU results are queued in a small FIFO and retire one per cycle into the
// register file. Read ports forward the youngest buffered result for the
// requested register, so a result is readable from the cycle after acceptance.
module ysyx_25060173_wb_regfile #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input logic                         clk,
  input logic                         rst,
  ysyx_25060173_wb_regfile_if.slave   bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] regs_q     [32];
  logic [XLEN-1:0] regs_d     [32];
  logic [4:0]      buf_rd_q   [DEPTH];
  logic [4:0]      buf_rd_d   [DEPTH];
  logic [XLEN-1:0] buf_data_q [DEPTH];
  logic [XLEN-1:0] buf_data_d [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            ready;
  logic            push;
  logic            retire;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  // Ready depends only on registered occupancy, never on wb_valid.
  assign ready     = (count_q != CW'(DEPTH));
  assign retire    = (count_q != '0);
  assign head_rd   = buf_rd_q[rptr_q];
  assign head_data = buf_data_q[rptr_q];
  // Transfers that do not write a real register complete without storing.
  assign push      = bus.wb_valid && ready && bus.wb_wen && (bus.wb_rd != 5'd0);

  assign bus.wb_ready     = ready;
  assign bus.wb_empty     = (count_q == '0);
  assign bus.commit_valid = retire;
  assign bus.commit_rd    = head_rd;
  assign bus.commit_data  = head_data;

  // Operand read: x0 is zero, else youngest valid buffered match, else regfile.
  // Entries are scanned oldest to youngest so the last match wins.
  function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
    logic [XLEN-1:0] val;
    logic [PW-1:0]   idx;
    val = regs_q[addr];
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr_q + PW'(i);
      if ((i < int'(count_q)) && (buf_rd_q[idx] == addr)) begin
        val = buf_data_q[idx];
      end
    end
    if (addr == 5'd0) begin
      val = '0;
    end
    return val;
  endfunction

  // Combinational read ports.
  always_comb begin
    bus.rs1_data = read_port(bus.rs1_addr);
    bus.rs2_data = read_port(bus.rs2_addr);
  end

  // Next state: push at write pointer, retire head into the register file.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = regs_q[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      buf_rd_d[i]   = buf_rd_q[i];
      buf_data_d[i] = buf_data_q[i];
    end

    if (push) begin
      buf_rd_d[wptr_q]   = bus.wb_rd;
      buf_data_d[wptr_q] = bus.wb_data;
      wptr_d             = wptr_q + PW'(1);
    end

    if (retire) begin
      regs_d[head_rd] = head_data;
      rptr_d          = rptr_q + PW'(1);
    end
    regs_d[0] = '0;

    case ({push, retire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Register file and buffer pointers; reset clears architectural state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Buffer payload; validity is tracked by count, so no reset needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      buf_rd_q[i]   <= buf_rd_d[i];
      buf_data_q[i] <= buf_data_d[i];
    end
  end

endmodule

// File: tb/tb_ysyx_25060173_wb_regfile.sv
// Directed bench for the writeback buffer / register file with a commit
// scoreboard and a reference register image.
module tb_ysyx_25060173_wb_regfile;

  logic clk;
  logic rst;
  int   n_asserts;
  int   n_fail;

  logic [36:0] exp_q[$];
  logic [31:0] model_regs[32];

  ysyx_25060173_wb_regfile_if #(.XLEN(32)) bus ();

  ysyx_25060173_wb_regfile #(.XLEN(32), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic wen, input logic [4:0] rd, input logic [31:0] data);
    bus.wb_valid = v;
    bus.wb_wen   = wen;
    bus.wb_rd    = rd;
    bus.wb_data  = data;
  endtask

  task automatic rd1(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    bus.rs1_addr = addr;
    #1;
    chk(tag, bus.rs1_data, exp);
  endtask

  task automatic rd2(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    bus.rs2_addr = addr;
    #1;
    chk(tag, bus.rs2_data, exp);
  endtask

  // One clock: check/pop the commit at mid-cycle, record the accepted push,
  // then advance past the rising edge.
  task automatic cycle();
    logic [36:0] e;
    logic        do_push;
    @(negedge clk);
    do_push = 1'b0;
    if (!rst) begin
      chk("commit_valid", {31'd0, bus.commit_valid}, {31'd0, (exp_q.size() != 0)});
      if (bus.commit_valid && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("commit_rd", {27'd0, bus.commit_rd}, {27'd0, e[36:32]});
        chk("commit_data", bus.commit_data, e[31:0]);
        model_regs[e[36:32]] = e[31:0];
      end
      do_push = bus.wb_valid && bus.wb_ready && bus.wb_wen && (bus.wb_rd != 5'd0);
      if (do_push) exp_q.push_back({bus.wb_rd, bus.wb_data});
    end
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    end
    #1;
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    bus.rs1_addr = 5'd0;
    bus.rs2_addr = 5'd0;

    // Reset state
    cycle();
    cycle();
    rd1("rst_rs1_x5", 5'd5, 32'd0);
    rd2("rst_rs2_x0", 5'd0, 32'd0);
    chk("rst_ready", {31'd0, bus.wb_ready}, 32'd1);
    chk("rst_empty", {31'd0, bus.wb_empty}, 32'd1);
    chk("rst_commit_valid", {31'd0, bus.commit_valid}, 32'd0);
    rst = 1'b0;

    // Single push, forwarding then regfile
    drive(1'b1, 1'b1, 5'd3, 32'h0000_0010);
    cycle();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    rd1("fwd_x3", 5'd3, 32'h10);
    chk("single_cv", {31'd0, bus.commit_valid}, 32'd1);
    chk("single_crd", {27'd0, bus.commit_rd}, 32'd3);
    chk("single_empty0", {31'd0, bus.wb_empty}, 32'd0);
    cycle();
    chk("single_empty1", {31'd0, bus.wb_empty}, 32'd1);
    rd1("rf_x3", 5'd3, 32'h10);

    // Non-storing transfers: rd=0 and wen=0
    drive(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    #1;
    chk("x0push_ready", {31'd0, bus.wb_ready}, 32'd1);
    cycle();
    chk("x0push_cv", {31'd0, bus.commit_valid}, 32'd0);
    chk("x0push_empty", {31'd0, bus.wb_empty}, 32'd1);
    drive(1'b1, 1'b0, 5'd4, 32'h55);
    cycle();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    chk("nowen_cv", {31'd0, bus.commit_valid}, 32'd0);
    rd1("nowen_x0", 5'd0, 32'd0);
    rd2("nowen_x4", 5'd4, 32'd0);

    // Back-to-back duplicates to x7
    drive(1'b1, 1'b1, 5'd7, 32'd1);
    cycle();
    rd1("dup_x7_a", 5'd7, 32'd1);
    drive(1'b1, 1'b1, 5'd7, 32'd2);
    cycle();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    rd1("dup_x7_b", 5'd7, 32'd2);
    cycle();
    rd1("dup_x7_rf", 5'd7, 32'd2);
    chk("dup_model_x7", model_regs[7], 32'd2);
    chk("dup_empty", {31'd0, bus.wb_empty}, 32'd1);

    // Streaming pushes: push and retire balance, ready stays high
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 5'(8 + i), 32'h100 + 32'(i));
      #1;
      chk("stream_ready", {31'd0, bus.wb_ready}, 32'd1);
      cycle();
    end
    rd1("stream_fwd_x17", 5'd17, 32'h109);
    rd2("stream_rf_x16", 5'd16, 32'h108);

    // Reset mid-stream with an entry still buffered
    rst = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    cycle();
    rst = 1'b0;
    chk("mrst_ready", {31'd0, bus.wb_ready}, 32'd1);
    chk("mrst_empty", {31'd0, bus.wb_empty}, 32'd1);
    chk("mrst_cv", {31'd0, bus.commit_valid}, 32'd0);
    rd1("mrst_x17", 5'd17, 32'd0);
    rd2("mrst_x8", 5'd8, 32'd0);
    cycle();
    rd1("mrst_x17_later", 5'd17, 32'd0);

    // Pointer wrap: six isolated pushes
    for (int r = 1; r <= 6; r++) begin
      drive(1'b1, 1'b1, 5'(r), 32'(r) * 32'h11);
      cycle();
      drive(1'b0, 1'b0, 5'd0, 32'd0);
      cycle();
    end
    chk("wrap_empty", {31'd0, bus.wb_empty}, 32'd1);
    for (int r = 1; r <= 6; r++) begin
      rd1("wrap_rf", 5'(r), 32'(r) * 32'h11);
      rd2("wrap_model", 5'(r), model_regs[r]);
    end
    rd1("wrap_x7_cleared", 5'd7, 32'd0);

    cycle();
    chk("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
